// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single asynchronous SRAM with
// active-low read/write strobes and a shared tristate data bus. Each granted
// access walks SETUP -> STROBE -> HOLD, so grants are at least four cycles apart.
module ram_arbiter #(
  parameter int SIZE    = 1024,
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = $clog2(SIZE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic               we0,
  input  logic               we1,
  input  logic [A_WIDTH-1:0] addr0,
  input  logic [A_WIDTH-1:0] addr1,
  input  logic [D_WIDTH-1:0] wdata0,
  input  logic [D_WIDTH-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [D_WIDTH-1:0] rdata,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_rdN,
  output logic               ram_wrN,
  inout  tri   [D_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t state;
  state_t next_state;

  // Round-robin pointer: 0 means requester 0 wins the next tie.
  logic prio;

  // Transaction captured when a request is accepted.
  logic               lat_we;
  logic               lat_grant;
  logic [A_WIDTH-1:0] lat_addr;
  logic [D_WIDTH-1:0] lat_wdata;

  // Registered bus driver enable and the next values of registered outputs.
  logic drive_en;
  logic start;
  logic pick;
  logic eff_we;
  logic eff_grant;
  logic next_drive_en;
  logic next_rdN;
  logic next_wrN;
  logic next_ack0;
  logic next_ack1;

  // Arbitration, next state, and next values of the registered outputs.
  always_comb begin
    next_state    = state;
    start         = 1'b0;
    pick          = 1'b0;
    eff_we        = lat_we;
    eff_grant     = lat_grant;
    next_drive_en = 1'b0;
    next_rdN      = 1'b1;
    next_wrN      = 1'b1;
    next_ack0     = 1'b0;
    next_ack1     = 1'b0;

    if (req0 && req1) begin
      pick = prio;
    end else if (req1) begin
      pick = 1'b1;
    end

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start      = 1'b1;
          next_state = SETUP;
        end
      end
      SETUP:   next_state = STROBE;
      STROBE:  next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    if (start) begin
      eff_we    = pick ? we1 : we0;
      eff_grant = pick;
    end

    next_drive_en = (next_state != IDLE) && eff_we;
    next_rdN      = !((next_state == STROBE) && !eff_we);
    next_wrN      = !((next_state == STROBE) && eff_we);
    next_ack0     = (next_state == HOLD) && !eff_grant;
    next_ack1     = (next_state == HOLD) && eff_grant;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the winner's request and advance the round-robin pointer on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio      <= 1'b0;
      lat_we    <= 1'b0;
      lat_grant <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (start) begin
      prio      <= ~pick;
      lat_we    <= pick ? we1 : we0;
      lat_grant <= pick;
      lat_addr  <= pick ? addr1 : addr0;
      lat_wdata <= pick ? wdata1 : wdata0;
    end
  end

  // Registered strobes, acks and bus enable so the RAM control lines cannot glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_rdN  <= 1'b1;
      ram_wrN  <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      ram_rdN  <= next_rdN;
      ram_wrN  <= next_wrN;
      ack0     <= next_ack0;
      ack1     <= next_ack1;
      drive_en <= next_drive_en;
    end
  end

  // Sample the RAM bus at the end of a read strobe; hold it until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if ((state == STROBE) && !lat_we) begin
      rdata <= ram_data;
    end
  end

  assign ram_addr = lat_addr;
  assign ram_data = drive_en ? lat_wdata : {D_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a behavioural SRAM on the shared bus, directed and
// randomized requests, and a transaction-level reference model.
module tb_ram_arbiter;

  localparam int SIZE    = 1024;
  localparam int D_WIDTH = 8;
  localparam int A_WIDTH = $clog2(SIZE);

  logic               clk = 1'b0;
  logic               rst;
  logic               req0, req1, we0, we1;
  logic [A_WIDTH-1:0] addr0, addr1;
  logic [D_WIDTH-1:0] wdata0, wdata1;
  logic               ack0, ack1;
  logic [D_WIDTH-1:0] rdata;
  logic [A_WIDTH-1:0] ram_addr;
  logic               ram_rdN, ram_wrN;
  tri   [D_WIDTH-1:0] ram_data;

  logic [D_WIDTH-1:0] ram_mem [SIZE];

  int checks = 0;
  int errors = 0;

  logic [D_WIDTH-1:0] model_mem [SIZE];
  bit                 model_known [SIZE];
  int                 prefer;
  logic [D_WIDTH-1:0] model_rdata;

  ram_arbiter #(.SIZE(SIZE), .D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ram_addr(ram_addr), .ram_rdN(ram_rdN), .ram_wrN(ram_wrN),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM: drives the bus while read strobe is low, stores while write strobe is low.
  assign ram_data = (ram_rdN === 1'b0) ? ram_mem[ram_addr] : {D_WIDTH{1'bz}};

  // SRAM write port.
  always @(posedge clk) begin
    if (ram_wrN === 1'b0) ram_mem[ram_addr] <= ram_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checkOutput(tag, 32'(obs), 32'(exp));
  endtask

  // Undriven bus reads as Z in a 4-state simulator and as 0 in a 2-state one.
  function automatic bit busReleased();
    return (ram_data === {D_WIDTH{1'bz}}) || (ram_data === {D_WIDTH{1'b0}});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    assert (!(ram_rdN === 1'b0 && ram_wrN === 1'b0)) else begin
      errors++;
      $error("[TB] FAIL strobe_overlap: rdN=%b wrN=%b, required not both 0", ram_rdN, ram_wrN);
    end
  endtask

  task automatic checkPhase(input string ph, input bit e_ack0, input bit e_ack1,
                            input bit e_rdN, input bit e_wrN, input bit chk_addr,
                            input logic [A_WIDTH-1:0] a, input bit chk_bus, input bit drive,
                            input logic [D_WIDTH-1:0] d, input logic [D_WIDTH-1:0] e_rdata);
    checkBit({ph, "_ack0"}, ack0, e_ack0);
    checkBit({ph, "_ack1"}, ack1, e_ack1);
    checkBit({ph, "_rdN"}, ram_rdN, e_rdN);
    checkBit({ph, "_wrN"}, ram_wrN, e_wrN);
    checkOutput({ph, "_rdata"}, 32'(rdata), 32'(e_rdata));
    if (chk_addr) checkOutput({ph, "_addr"}, 32'(ram_addr), 32'(a));
    if (chk_bus) begin
      if (drive) checkOutput({ph, "_bus"}, 32'(ram_data), 32'(d));
      else if (d != '0) checkBit({ph, "_release"}, busReleased(), 1'b1);
    end
  endtask

  // Presents one request set while the arbiter is idle and follows the resulting access.
  task automatic applyStimulus(input bit r0, input bit w0, input logic [A_WIDTH-1:0] a0,
                               input logic [D_WIDTH-1:0] d0, input bit r1, input bit w1,
                               input logic [A_WIDTH-1:0] a1, input logic [D_WIDTH-1:0] d1,
                               input bit keep, output int win);
    bit                 w;
    bit                 scramble;
    logic [A_WIDTH-1:0] a_w;
    logic [D_WIDTH-1:0] d_w;
    logic [D_WIDTH-1:0] old_rdata;
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    if (!r0 && !r1) begin
      win = -1;
      for (int k = 0; k < 2; k++) begin
        tick();
        checkPhase("noreq", 0, 0, 1, 1, 0, '0, 0, 0, '0, model_rdata);
      end
      return;
    end
    win      = (r0 && r1) ? prefer : (r1 ? 1 : 0);
    prefer   = 1 - win;
    w        = (win == 1) ? w1 : w0;
    a_w      = (win == 1) ? a1 : a0;
    d_w      = (win == 1) ? d1 : d0;
    scramble = (win == 1) ? !r0 : !r1;
    old_rdata = model_rdata;

    tick();
    if (scramble) begin
      if (win == 1) begin
        req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = A_WIDTH'($urandom); wdata0 = D_WIDTH'($urandom);
      end else begin
        req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = A_WIDTH'($urandom); wdata1 = D_WIDTH'($urandom);
      end
    end
    checkPhase("setup", 0, 0, 1, 1, 1, a_w, 1, w, d_w, old_rdata);

    tick();
    checkPhase("strobe", 0, 0, w, !w, 1, a_w, w, w, d_w, old_rdata);
    if (scramble) begin
      if (win == 1) req0 = 1'b0;
      else req1 = 1'b0;
    end

    tick();
    if (w) begin
      model_mem[a_w]   = d_w;
      model_known[a_w] = 1'b1;
    end else begin
      model_rdata = model_mem[a_w];
    end
    checkPhase("hold", win == 0, win == 1, 1, 1, 1, a_w, 1, w, d_w, model_rdata);
    if (!keep) begin
      if (win == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end

    tick();
    checkPhase("idle", 0, 0, 1, 1, 0, a_w, 1, 0, d_w, model_rdata);
  endtask

  initial begin
    int                 win;
    bit                 p0, p1, pw0, pw1;
    logic [A_WIDTH-1:0] pa0, pa1;
    logic [D_WIDTH-1:0] pd0, pd1;

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    prefer = 0;
    model_rdata = '0;
    tick();
    tick();
    checkBit("reset_rdN", ram_rdN, 1'b1);
    checkBit("reset_wrN", ram_wrN, 1'b1);
    checkBit("reset_ack0", ack0, 1'b0);
    checkBit("reset_ack1", ack1, 1'b0);
    checkOutput("reset_rdata", 32'(rdata), 32'h0);
    checkBit("reset_release", busReleased(), 1'b1);
    rst = 1'b0;
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0, 0, win);

    $display("[TB] single write and readback");
    applyStimulus(1, 1, A_WIDTH'(5), 8'hA5, 0, 0, '0, '0, 0, win);
    checkOutput("ram_word5", 32'(ram_mem[5]), 32'hA5);
    applyStimulus(0, 0, '0, '0, 1, 0, A_WIDTH'(5), 8'h3C, 0, win);

    $display("[TB] address bounds");
    applyStimulus(1, 1, A_WIDTH'(0), 8'hC3, 0, 0, '0, '0, 0, win);
    applyStimulus(0, 0, '0, '0, 1, 1, A_WIDTH'(SIZE - 1), 8'h3C, 0, win);
    applyStimulus(1, 1, A_WIDTH'(1), 8'h96, 0, 0, '0, '0, 0, win);
    applyStimulus(0, 0, '0, '0, 1, 1, A_WIDTH'(SIZE - 2), 8'h69, 0, win);
    applyStimulus(0, 0, '0, '0, 1, 0, A_WIDTH'(0), 8'h11, 0, win);
    applyStimulus(1, 0, A_WIDTH'(SIZE - 1), 8'h22, 0, 0, '0, '0, 0, win);
    applyStimulus(0, 0, '0, '0, 1, 0, A_WIDTH'(1), 8'h33, 0, win);
    applyStimulus(1, 0, A_WIDTH'(SIZE - 2), 8'h44, 0, 0, '0, '0, 0, win);

    $display("[TB] preload random address pool");
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        applyStimulus(1, 1, A_WIDTH'(32 + i), D_WIDTH'($urandom_range(1, 255)), 0, 0, '0, '0, 0, win);
      else
        applyStimulus(0, 0, '0, '0, 1, 1, A_WIDTH'(32 + i), D_WIDTH'($urandom_range(1, 255)), 0, win);
    end

    $display("[TB] contention with both requests held");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, A_WIDTH'(40), 8'h77, 1, 0, A_WIDTH'(40), 8'h5E, 1, win);
    end
    req0 = 1'b0; req1 = 1'b0;

    $display("[TB] reset during write strobe");
    applyStimulus(0, 0, '0, '0, 1, 0, A_WIDTH'(33), 8'h12, 0, win);
    req0 = 1'b1; we0 = 1'b1; addr0 = A_WIDTH'(20); wdata0 = 8'h5A;
    tick();
    tick();
    checkBit("abort_strobe_wrN", ram_wrN, 1'b0);
    rst = 1'b1;
    tick();
    checkBit("abort_wrN", ram_wrN, 1'b1);
    checkBit("abort_rdN", ram_rdN, 1'b1);
    checkBit("abort_ack0", ack0, 1'b0);
    checkBit("abort_ack1", ack1, 1'b0);
    checkBit("abort_release", busReleased(), 1'b1);
    checkOutput("abort_rdata", 32'(rdata), 32'h0);
    rst = 1'b0; req0 = 1'b0;
    prefer = 0;
    model_rdata = '0;
    model_known[20] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkPhase("after_abort", 0, 0, 1, 1, 0, '0, 0, 0, '0, model_rdata);
    end
    applyStimulus(1, 0, A_WIDTH'(34), 8'h11, 1, 0, A_WIDTH'(35), 8'h22, 0, win);

    $display("[TB] randomized traffic");
    p0 = 1'b0; p1 = 1'b0;
    pw0 = 1'b0; pw1 = 1'b0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
    for (int i = 0; i < 80; i++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1'b1; pw0 = 1'($urandom_range(0, 1));
        pa0 = A_WIDTH'(32 + $urandom_range(0, 15)); pd0 = D_WIDTH'($urandom_range(1, 255));
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1'b1; pw1 = 1'($urandom_range(0, 1));
        pa1 = A_WIDTH'(32 + $urandom_range(0, 15)); pd1 = D_WIDTH'($urandom_range(1, 255));
      end
      applyStimulus(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, 0, win);
      if (win == 0) p0 = 1'b0;
      else if (win == 1) p1 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
